add_result_stage: RTL and testbench

//  - Registered output stage directly downstream of the 4-bit ripple full adder (fulladder).
//  - Captures operands a/b, sum and cout, and derives signed status flags V/C/N/Z.
//  - Buffers results in a 2-entry skid FIFO with valid/ready on both sides.
//  - Keeps a saturating count of signed-overflow events for the ALU status block.

---
 rtl/add_pkg.sv | 26 ++
 rtl/add_result_stage_if.sv | 29 ++
 rtl/add_flag_calc.sv | 35 +++
 rtl/add_result_stage.sv | 103 ++++++++++
 tb/tb_add_result_stage.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the adder result stage: default width, flag layout
// and the occupancy states of the two-entry output buffer.
package add_pkg;

  localparam int ADD_WIDTH = 4;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Packed so that v lands on bit FLAG_V and z on bit FLAG_Z.
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } add_flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/add_result_stage_if.sv
// Push and pop handshake bundle between the adder, the result stage and its consumer.
interface add_result_stage_if #(
  parameter int WIDTH = add_pkg::ADD_WIDTH
);

  // A beat transfers on a rising edge where valid && ready. The sender holds
  // its payload stable until accepted; ready may be low without valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/add_flag_calc.sv
// Combinational V/C/N/Z derivation and optional overflow clamping.
// Clamping is compiled in when ADD_RESULT_SATURATE_EN is defined.
module add_flag_calc
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [WIDTH-1:0] result,
  output add_flags_t       flags
);

  logic v;

  // Signed overflow: like-signed operands producing a differently-signed sum.
  assign v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result = sum;
`ifdef ADD_RESULT_SATURATE_EN
    // Operand sign tells which rail was crossed.
    if (v) begin
      result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags.v = v;
    flags.c = cout;
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
  end

endmodule

// File: rtl/add_result_stage.sv
// Registered output stage behind the ripple adder: flag capture, two-entry skid FIFO,
// saturating overflow counter. Optional clamping via ADD_RESULT_SATURATE_EN.
module add_result_stage
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  add_result_stage_if.slave    s,
  output logic [CNT_W-1:0]     ovf_count,
  input  logic                 clr_count,
  output occ_t                 occ_state
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    add_flags_t       flags;
  } entry_t;

  occ_t             state_q;
  occ_t             state_d;
  entry_t           head_q;
  entry_t           tail_q;
  entry_t           cap;
  logic             in_ready_q;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt_q;

  add_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .a      (s.in_a),
    .b      (s.in_b),
    .sum    (s.in_sum),
    .cout   (s.in_cout),
    .result (cap.result),
    .flags  (cap.flags)
  );

  assign push = s.in_valid && in_ready_q;
  assign pop  = (state_q != EMPTY) && s.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next occupancy, so it stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Head drives the outputs and is left untouched when the buffer drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: if (push) head_q <= cap;
        ONE: begin
          if (push && pop) head_q <= cap;
          else if (push)   tail_q <= cap;
        end
        FULL:    if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_count) begin
      cnt_q <= '0;
    end else if (push && cap.flags.v && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign s.in_ready   = in_ready_q;
  assign s.out_valid  = (state_q != EMPTY);
  assign s.out_result = head_q.result;
  assign s.out_flags  = head_q.flags;
  assign ovf_count    = cnt_q;
  assign occ_state    = state_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Randomized and directed bench for add_result_stage against a queue-based reference model.
module tb_add_result_stage;
  import add_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_count;
  logic [CW-1:0] ovf_count;
  occ_t          occ_state;

  add_result_stage_if #(.WIDTH(W)) bus ();

  add_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus.slave),
    .ovf_count (ovf_count),
    .clr_count (clr_count),
    .occ_state (occ_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W+3:0]  exp_q[$];     // {result, flags}
  logic [W+3:0]  exp_head;
  logic          exp_in_ready;
  logic [CW-1:0] exp_cnt;
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operands.
  function automatic logic [W+3:0] ref_entry(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, ssum, usum, res;
    int lo, hi;
    logic v, c;
    logic [W-1:0] r;
    sa   = $signed(a);
    sb   = $signed(b);
    ssum = sa + sb;
    usum = int'(a) + int'(b);
    lo   = -(1 << (W - 1));
    hi   = (1 << (W - 1)) - 1;
    v    = (ssum < lo) || (ssum > hi);
    c    = (usum >= (1 << W));
    res  = usum % (1 << W);
`ifdef ADD_RESULT_SATURATE_EN
    if (v) res = (ssum > hi) ? hi : lo;
`endif
    r = res[W-1:0];
    return {r, v, c, r[W-1], (r == '0)};
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),   32'(exp_in_ready));
    check({tag, "_out_valid"}, 32'(bus.out_valid),  32'(exp_q.size() > 0));
    check({tag, "_result"},    32'(bus.out_result), 32'(exp_head[W+3:4]));
    check({tag, "_flags"},     32'(bus.out_flags),  32'(exp_head[3:0]));
    check({tag, "_ovf_count"}, 32'(ovf_count),      32'(exp_cnt));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy, input logic clr, input string tag);
    logic push, pop;
    logic [W+3:0] e;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    {bus.in_cout, bus.in_sum} = a + b;
    bus.out_ready = ordy;
    clr_count     = clr;
    @(posedge clk);
    push = v && exp_in_ready;
    pop  = (exp_q.size() > 0) && ordy;
    e    = ref_entry(a, b);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(e);
    if (exp_q.size() > 0) exp_head = exp_q[0];
    exp_in_ready = (exp_q.size() < 2);
    if (clr) exp_cnt = '0;
    else if (push && e[3] && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asynchronous reset pulse asserted mid-cycle.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_head     = '0;
    exp_in_ready = 1'b0;
    exp_cnt      = '0;
    compare_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b1, 1'b0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    clr_count     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sum    = '0;
    bus.in_cout   = 1'b0;
    bus.out_ready = 1'b0;
    exp_head      = '0;
    exp_in_ready  = 1'b0;
    exp_cnt       = '0;

    @(negedge clk);
    do_reset("reset");
    idle("post_reset");
    check("in_ready_rise", 32'(bus.in_ready), 32'd1);

    // Reference vectors; out_ready=1 keeps the newest entry at the head.
    step(1'b1, 4'h4, 4'h3, 1'b1, 1'b0, "vec1");
    check("vec1_res", 32'(bus.out_result), 32'h7);
    check("vec1_flg", 32'(bus.out_flags),  32'b0000);
    check("vec1_cnt", 32'(ovf_count),      32'd0);
    step(1'b1, 4'hC, 4'h7, 1'b1, 1'b0, "vec2");
    check("vec2_res", 32'(bus.out_result), 32'h3);
    check("vec2_flg", 32'(bus.out_flags),  32'b0100);
    step(1'b1, 4'h5, 4'h7, 1'b1, 1'b0, "vec3");
`ifdef ADD_RESULT_SATURATE_EN
    check("vec3_res", 32'(bus.out_result), 32'h7);
    check("vec3_flg", 32'(bus.out_flags),  32'b1000);
`else
    check("vec3_res", 32'(bus.out_result), 32'hC);
    check("vec3_flg", 32'(bus.out_flags),  32'b1010);
`endif
    check("vec3_cnt", 32'(ovf_count), 32'd1);
    step(1'b1, 4'hA, 4'h8, 1'b1, 1'b0, "vec4");
`ifdef ADD_RESULT_SATURATE_EN
    check("vec4_res", 32'(bus.out_result), 32'h8);
    check("vec4_flg", 32'(bus.out_flags),  32'b1110);
`else
    check("vec4_res", 32'(bus.out_result), 32'h2);
    check("vec4_flg", 32'(bus.out_flags),  32'b1100);
`endif
    check("vec4_cnt", 32'(ovf_count), 32'd2);
    idle("drain");
    check("drain_hold_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: third beat is held upstream until space frees.
    step(1'b1, 4'h1, 4'h1, 1'b0, 1'b0, "bp1");
    step(1'b1, 4'h2, 4'h2, 1'b0, 1'b0, "bp2");
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 4'h3, 4'h3, 1'b0, 1'b0, "bp3");
    check("bp_hold_res", 32'(bus.out_result), 32'h2);
    step(1'b1, 4'h3, 4'h3, 1'b1, 1'b0, "bp_rel1");
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    check("bp_order2", 32'(bus.out_result), 32'h4);
    step(1'b1, 4'h3, 4'h3, 1'b1, 1'b0, "bp_rel2");
    check("bp_order3", 32'(bus.out_result), 32'h6);
    idle("bp_drain");

    // Clear wins over a same-cycle overflow push.
    step(1'b1, 4'h5, 4'h7, 1'b1, 1'b1, "clr_ovf");
    check("clr_ovf_cnt", 32'(ovf_count), 32'd0);

    // Counter saturation.
    for (int i = 0; i < 300; i++) step(1'b1, 4'h5, 4'h7, 1'b1, 1'b0, "sat_run");
    check("cnt_saturated", 32'(ovf_count), 32'hFF);

    // Reset while FULL.
    step(1'b1, 4'h1, 4'h2, 1'b0, 1'b0, "fill1");
    step(1'b1, 4'h3, 4'h4, 1'b0, 1'b0, "fill2");
    check("fill_state", 32'(bus.in_ready), 32'd0);
    do_reset("rst_full");
    idle("rst_full_release");
    check("rst_full_ready", 32'(bus.in_ready), 32'd1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rand_rst");
      end else begin
        step(1'($urandom_range(0, 3) != 0),
             W'($urandom_range(0, (1 << W) - 1)),
             W'($urandom_range(0, (1 << W) - 1)),
             1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 63) == 0),
             "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
